// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic imem_busy;
    logic dmem_busy;
    logic bubble_d;
    logic branch_e;
    logic serial_d;
  } hazard_req_t;

  typedef struct packed {
    logic hold_f;
    logic hold_d;
    logic hold_e;
    logic kill_f;
    logic kill_d;
    logic kill_m;
  } pipe_ctrl_t;

  // Reset view of the pipeline: nothing holds, every register loads a bubble.
  function automatic pipe_ctrl_t flush_all();
    pipe_ctrl_t c;
    c        = '0;
    c.kill_f = 1'b1;
    c.kill_d = 1'b1;
    c.kill_m = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipeline: hazard merge, CSR drain FSM,
// stall watchdog and saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  input  logic             bubble_d,
  input  logic             branch_e,
  input  logic             valid_d,
  input  logic             serial_d,
  input  logic             valid_e,
  input  logic             valid_m,
  input  logic             valid_w,
  output logic             hold_f,
  output logic             hold_d,
  output logic             hold_e,
  output logic             kill_f,
  output logic             kill_d,
  output logic             kill_m,
  output logic             draining,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  hazard_req_t  req;
  pipe_ctrl_t   ctrl;
  ctrl_state_t  state_q, state_d;
  logic         pipe_busy;
  logic         stall_timeout_q, stall_timeout_d;
  logic         wd_inc;
  logic [WD_W-1:0] stall_cnt;

  assign req       = '{imem_busy: imem_busy, dmem_busy: dmem_busy, bubble_d: bubble_d,
                       branch_e: branch_e, serial_d: serial_d};
  assign pipe_busy = valid_e | valid_m | valid_w;

  always_comb begin
    ctrl        = '0;
    ctrl.hold_e = req.dmem_busy;
    ctrl.kill_m = req.dmem_busy;
    ctrl.hold_d = ctrl.hold_e;
    if (req.branch_e && !ctrl.hold_e) begin
      ctrl.kill_f = 1'b1;
      ctrl.kill_d = 1'b1;
    end else if (!req.branch_e) begin
      // DRAIN already kills D/E, so a load-use bubble adds nothing there.
      if (state_q == DRAIN) begin
        ctrl.hold_f = 1'b1;
        ctrl.kill_d = !ctrl.hold_e;
      end else if (req.bubble_d && !ctrl.hold_e) begin
        ctrl.hold_f = 1'b1;
        ctrl.kill_d = 1'b1;
      end
    end
    if (ctrl.hold_d) begin
      ctrl.hold_f = 1'b1;
    end
    if (req.imem_busy && !ctrl.hold_f && !req.branch_e) begin
      ctrl.kill_f = 1'b1;
    end
    ctrl.kill_f = ctrl.kill_f & ~ctrl.hold_f;
    ctrl.kill_d = ctrl.kill_d & ~ctrl.hold_d;
    if (!reset) begin
      ctrl = flush_all();
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (valid_d && req.serial_d && !req.dmem_busy && !req.branch_e && !req.bubble_d
            && pipe_busy) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (req.branch_e) begin
          state_d = RUN;
        end else if (!pipe_busy && !req.dmem_busy) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!req.dmem_busy) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Watchdog count stops at TIMEOUT; the flag is set on the edge that reaches it.
  assign wd_inc          = ctrl.hold_f && (stall_cnt != WD_W'(TIMEOUT));
  assign stall_timeout_d = stall_timeout_q | (wd_inc && (stall_cnt == WD_W'(TIMEOUT - 1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= RUN;
      stall_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  sat_counter #(.W(WD_W)) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .inc   (wd_inc),
    .clear (!ctrl.hold_f),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (ctrl.hold_f),
    .clear (1'b0),
    .count (cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .reset (reset),
    .inc   (req.branch_e && !ctrl.hold_e),
    .clear (1'b0),
    .count (cnt_flush)
  );

  assign hold_f        = ctrl.hold_f;
  assign hold_d        = ctrl.hold_d;
  assign hold_e        = ctrl.hold_e;
  assign kill_f        = ctrl.kill_f;
  assign kill_d        = ctrl.kill_d;
  assign kill_m        = ctrl.kill_m;
  assign draining      = reset && (state_q == DRAIN);
  assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vectors plus a per-cycle reference model.
module tb_pipe_ctrl;

  localparam int unsigned TMO  = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  localparam logic [8:0] IM = 9'h100;
  localparam logic [8:0] DM = 9'h080;
  localparam logic [8:0] BU = 9'h040;
  localparam logic [8:0] BR = 9'h020;
  localparam logic [8:0] VD = 9'h010;
  localparam logic [8:0] SD = 9'h008;
  localparam logic [8:0] VE = 9'h004;
  localparam logic [8:0] VM = 9'h002;
  localparam logic [8:0] VW = 9'h001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic imem_busy = 1'b0, dmem_busy = 1'b0, bubble_d = 1'b0, branch_e = 1'b0;
  logic valid_d = 1'b0, serial_d = 1'b0, valid_e = 1'b0, valid_m = 1'b0, valid_w = 1'b0;
  logic hold_f, hold_d, hold_e, kill_f, kill_d, kill_m, draining, stall_timeout;
  logic [CW-1:0] cnt_stall, cnt_flush;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  // Model state: mode 0 = normal, 1 = waiting for E/M/W to empty, 2 = release cycle.
  int m_mode  = 0;
  int m_stall = 0;
  int m_cs    = 0;
  int m_cf    = 0;
  bit m_tmo   = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_busy     (imem_busy),
    .dmem_busy     (dmem_busy),
    .bubble_d      (bubble_d),
    .branch_e      (branch_e),
    .valid_d       (valid_d),
    .serial_d      (serial_d),
    .valid_e       (valid_e),
    .valid_m       (valid_m),
    .valid_w       (valid_w),
    .hold_f        (hold_f),
    .hold_d        (hold_d),
    .hold_e        (hold_e),
    .kill_f        (kill_f),
    .kill_d        (kill_d),
    .kill_m        (kill_m),
    .draining      (draining),
    .stall_timeout (stall_timeout),
    .cnt_stall     (cnt_stall),
    .cnt_flush     (cnt_flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Returns {hold_f, hold_d, hold_e, kill_f, kill_d, kill_m} for the current inputs.
  function automatic logic [5:0] mdl();
    bit hf, hd, he, kf, kd, km;
    if (!reset) return 6'b000111;
    he = dmem_busy; km = dmem_busy; hd = dmem_busy;
    hf = 0; kf = 0; kd = 0;
    if (branch_e) begin
      if (!dmem_busy) begin kf = 1; kd = 1; end
    end else if (m_mode == 1) begin
      hf = 1; kd = !dmem_busy;
    end else if (bubble_d && !dmem_busy) begin
      hf = 1; kd = 1;
    end
    if (hd) hf = 1;
    if (imem_busy && !hf && !branch_e) kf = 1;
    if (hf) kf = 0;
    if (hd) kd = 0;
    return {hf, hd, he, kf, kd, km};
  endfunction

  always @(posedge clk) begin : model_update
    logic [5:0] o;
    int nm, ns;
    o  = mdl();
    nm = m_mode;
    ns = o[5] ? ((m_stall < TMO) ? m_stall + 1 : m_stall) : 0;
    if (!reset) begin
      m_mode <= 0; m_stall <= 0; m_cs <= 0; m_cf <= 0; m_tmo <= 1'b0;
    end else begin
      if (m_mode == 0 && valid_d && serial_d && !dmem_busy && !branch_e && !bubble_d
          && (valid_e || valid_m || valid_w)) nm = 1;
      else if (m_mode == 1 && branch_e) nm = 0;
      else if (m_mode == 1 && !valid_e && !valid_m && !valid_w && !dmem_busy) nm = 2;
      else if (m_mode == 2 && !dmem_busy) nm = 0;
      m_mode  <= nm;
      m_stall <= ns;
      if (ns == TMO) m_tmo <= 1'b1;
      if (o[5] && m_cs < CMAX) m_cs <= m_cs + 1;
      if (branch_e && !dmem_busy && m_cf < CMAX) m_cf <= m_cf + 1;
    end
    cyc_n <= cyc_n + 1;
  end

  always @(negedge clk) begin : model_compare
    logic [5:0] o;
    if (cyc_n > 0) begin
      o = mdl();
      chk("m_hold_f", 32'(hold_f), 32'(o[5]));
      chk("m_hold_d", 32'(hold_d), 32'(o[4]));
      chk("m_hold_e", 32'(hold_e), 32'(o[3]));
      chk("m_kill_f", 32'(kill_f), 32'(o[2]));
      chk("m_kill_d", 32'(kill_d), 32'(o[1]));
      chk("m_kill_m", 32'(kill_m), 32'(o[0]));
      chk("m_draining", 32'(draining), 32'(reset && m_mode == 1));
      chk("m_stall_timeout", 32'(stall_timeout), 32'(m_tmo));
      chk("m_cnt_stall", 32'(cnt_stall), 32'(m_cs));
      chk("m_cnt_flush", 32'(cnt_flush), 32'(m_cf));
    end
  end

  task automatic cyc(input logic r, input logic [8:0] v);
    @(posedge clk);
    #1;
    reset = r;
    {imem_busy, dmem_busy, bubble_d, branch_e, valid_d, serial_d, valid_e, valid_m, valid_w} = v;
    @(negedge clk);
  endtask

  function automatic logic [31:0] ctl();
    return 32'({hold_f, hold_d, hold_e, kill_f, kill_d, kill_m});
  endfunction

  initial begin
    // Reset with every input asserted
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 9'h1FF);
      chk("rst_ctrl", ctl(), 32'b000111);
      chk("rst_draining", 32'(draining), 32'd0);
    end
    cyc(1'b1, 9'h000);
    chk("post_rst_ctrl", ctl(), 32'b000000);
    chk("post_rst_cnt_stall", 32'(cnt_stall), 32'd0);
    chk("post_rst_cnt_flush", 32'(cnt_flush), 32'd0);
    chk("post_rst_timeout", 32'(stall_timeout), 32'd0);

    // Load-use bubble and imem busy
    cyc(1'b1, BU);
    chk("bubble_ctrl", ctl(), 32'b100010);
    cyc(1'b1, 9'h000);
    chk("bubble_gone", ctl(), 32'b000000);
    chk("bubble_cnt_stall", 32'(cnt_stall), 32'd1);
    cyc(1'b1, IM);
    chk("imem_ctrl", ctl(), 32'b000100);
    cyc(1'b1, IM | BU);
    chk("imem_bubble_ctrl", ctl(), 32'b100010);

    // Branch beats bubble; dmem_busy beats branch
    cyc(1'b1, BR | BU);
    chk("branch_ctrl", ctl(), 32'b000110);
    chk("branch_cnt_stall", 32'(cnt_stall), 32'd2);
    cyc(1'b1, BR | BU | DM);
    chk("branch_dmem_ctrl", ctl(), 32'b111001);
    chk("branch_cnt_flush", 32'(cnt_flush), 32'd1);
    cyc(1'b1, 9'h000);
    chk("branch_dmem_no_flush", 32'(cnt_flush), 32'd1);
    chk("branch_dmem_cnt_stall", 32'(cnt_stall), 32'd3);

    // Serialization drain, one downstream stage emptying per cycle
    cyc(1'b1, VD | SD | VE | VM | VW);
    chk("ser_enter_draining", 32'(draining), 32'd0);
    chk("ser_enter_ctrl", ctl(), 32'b000000);
    cyc(1'b1, VD | SD | VM | VW);
    chk("ser_d1", 32'(draining), 32'd1);
    chk("ser_d1_ctrl", ctl(), 32'b100010);
    cyc(1'b1, VD | SD | VW);
    chk("ser_d2", 32'(draining), 32'd1);
    cyc(1'b1, VD | SD);
    chk("ser_d3", 32'(draining), 32'd1);
    chk("ser_d3_ctrl", ctl(), 32'b100010);
    cyc(1'b1, VD | SD);
    chk("ser_issue_draining", 32'(draining), 32'd0);
    chk("ser_issue_ctrl", ctl(), 32'b000000);
    cyc(1'b1, VE);
    chk("ser_run_draining", 32'(draining), 32'd0);
    chk("ser_cnt_stall", 32'(cnt_stall), 32'd6);

    // Branch aborts a drain
    cyc(1'b1, VD | SD | VE);
    cyc(1'b1, VD | SD | VE | BR);
    chk("abort_draining", 32'(draining), 32'd1);
    chk("abort_ctrl", ctl(), 32'b000110);
    cyc(1'b1, 9'h000);
    chk("abort_after", 32'(draining), 32'd0);
    chk("abort_cnt_flush", 32'(cnt_flush), 32'd2);

    // Reset while draining
    cyc(1'b1, VD | SD | VE);
    cyc(1'b1, VD | SD | VE);
    chk("rstdrain_pre", 32'(draining), 32'd1);
    cyc(1'b0, VD | SD | VE);
    chk("rstdrain_ctrl", ctl(), 32'b000111);
    cyc(1'b1, 9'h000);
    chk("rstdrain_draining", 32'(draining), 32'd0);
    chk("rstdrain_cnt_stall", 32'(cnt_stall), 32'd0);
    chk("rstdrain_cnt_flush", 32'(cnt_flush), 32'd0);

    // Watchdog: ten cycles of dmem_busy, then counter saturation
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, DM);
      chk("wd_timeout", 32'(stall_timeout), (i >= 8) ? 32'd1 : 32'd0);
      chk("wd_cnt_stall", 32'(cnt_stall), 32'(i));
    end
    cyc(1'b1, 9'h000);
    chk("wd_sticky", 32'(stall_timeout), 32'd1);
    chk("wd_cnt_stall_10", 32'(cnt_stall), 32'd10);
    for (int i = 0; i < 6; i++) cyc(1'b1, DM);
    cyc(1'b1, 9'h000);
    chk("sat_cnt_stall", 32'(cnt_stall), 32'd15);
    chk("sat_sticky", 32'(stall_timeout), 32'd1);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
